// File: rtl/input_conditioner_if.sv
// input_conditioner_if
//   Groups the raw button/switch inputs, the game-FSM state code and the
//   conditioned outputs of the input conditioner.
//   master : the side driving raw inputs and consuming conditioned outputs
//   slave  : the conditioner itself
//   Signals:
//     enter_btn, restart_btn : raw asynchronous bouncing buttons, active-high
//     sw[3:0]                : raw asynchronous value switches
//     state[3:0]             : game-FSM state code, synchronous to clka
//     enter                  : one-cycle accepted-press pulse
//     restart                : debounced restart level
//     sw_val[3:0]            : switch value captured at the last accepted press
//     input_err              : one-cycle pulse on an out-of-range press
interface input_conditioner_if;
    logic       enter_btn;
    logic       restart_btn;
    logic [3:0] sw;
    logic [3:0] state;
    logic       enter;
    logic       restart;
    logic [3:0] sw_val;
    logic       input_err;

    modport master (
        output enter_btn, restart_btn, sw, state,
        input  enter, restart, sw_val, input_err
    );

    modport slave (
        input  enter_btn, restart_btn, sw, state,
        output enter, restart, sw_val, input_err
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner
//   Synchronizes and debounces the enter/restart buttons and the value
//   switches, then turns each debounced enter press into at most one
//   enter (valid value) or input_err (out-of-range value) pulse, judged
//   against the current game-FSM state code.
//   Ports:
//     clka      : sole clock, rising edge
//     restart_n : synchronous active-low reset
//     io        : input_conditioner_if.slave (buttons, switches, state in;
//                 enter, restart, sw_val, input_err out)
//   Parameter:
//     DEBOUNCE_CYCLES : consecutive stable cycles to accept a level change

// Per-button debounce cell: counts cycles where the synchronized input
// disagrees with the accepted level; accepts after N disagreeing cycles.
module ic_debounce #(
    parameter int N = 16
) (
    input  logic clka,
    input  logic restart_n,
    input  logic din,
    output logic level
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (din == level) begin
            cnt <= '0;
        end else if (cnt == CW'(N - 1)) begin
            // last disagreeing cycle: accept; counter stops here, never wraps
            level <= din;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clka,
    input  logic                 restart_n,
    input_conditioner_if.slave   io
);
    localparam int NUM_BTN = 2;  // [0] enter, [1] restart
    localparam int SYNC_W  = NUM_BTN + 4;

    typedef enum logic {WAIT_PRESS, WAIT_RELEASE} press_st_t;
    typedef enum logic [1:0] {V_IGNORE, V_VALID, V_INVALID} verdict_t;

    // ---------------- two-flop synchronizers ----------------
    logic [SYNC_W-1:0] raw, s1, s2;

    assign raw = {io.sw, io.restart_btn, io.enter_btn};

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    logic [3:0] sw_s;
    assign sw_s = s2[SYNC_W-1:NUM_BTN];

    // ---------------- debounce, one cell per button ----------------
    logic [NUM_BTN-1:0] db_lvl;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_db
            ic_debounce #(.N(DEBOUNCE_CYCLES)) u_db (
                .clka      (clka),
                .restart_n (restart_n),
                .din       (s2[gi]),
                .level     (db_lvl[gi])
            );
        end
    endgenerate

    logic db_enter, db_restart;
    assign db_enter   = db_lvl[0];
    assign db_restart = db_lvl[1];

    // ---------------- value range check ----------------
    verdict_t verdict;

    always_comb begin
        verdict = V_IGNORE;
        case (io.state)
            4'b0000, 4'b0010: verdict = V_VALID;
            4'b0011:          verdict = (sw_s <= 4'd2) ? V_VALID : V_INVALID;
            4'b0100, 4'b0101: verdict = (sw_s <= 4'd8) ? V_VALID : V_INVALID;
            4'b0110:          verdict = (sw_s >= 4'd1 && sw_s <= 4'd9) ? V_VALID : V_INVALID;
            default:          verdict = V_IGNORE;
        endcase
    end

    // ---------------- press FSM ----------------
    press_st_t  st_q, st_d;
    logic       enter_q, enter_d;
    logic       err_q, err_d;
    logic [3:0] sw_val_q, sw_val_d;

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            st_q     <= WAIT_PRESS;
            enter_q  <= 1'b0;
            err_q    <= 1'b0;
            sw_val_q <= '0;
        end else begin
            st_q     <= st_d;
            enter_q  <= enter_d;
            err_q    <= err_d;
            sw_val_q <= sw_val_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        enter_d  = 1'b0;
        err_d    = 1'b0;
        sw_val_d = sw_val_q;
        if (db_restart) begin
            // restart dominates; parking in WAIT_RELEASE means a press held
            // across restart must be released before it can count
            st_d = WAIT_RELEASE;
        end else begin
            case (st_q)
                WAIT_PRESS: begin
                    if (db_enter) begin
                        st_d = WAIT_RELEASE;
                        case (verdict)
                            V_VALID: begin
                                enter_d  = 1'b1;
                                sw_val_d = sw_s;
                            end
                            V_INVALID: err_d = 1'b1;
                            default:   ;
                        endcase
                    end
                end
                WAIT_RELEASE: begin
                    if (!db_enter) st_d = WAIT_PRESS;
                end
                default: st_d = WAIT_PRESS;
            endcase
        end
    end

    assign io.enter     = enter_q;
    assign io.input_err = err_q;
    assign io.sw_val    = sw_val_q;
    assign io.restart   = db_restart;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; the next rising edge is E1.
// After the i-th tick inside a loop the bench sits just past edge E1+i, so a
// press is expected to pulse at i==6 and the debounced level to flip at i==5.
module tb_input_conditioner;
    localparam int DC = 4;

    logic clka = 1'b0;
    logic restart_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    input_conditioner_if ifc ();

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clka      (clka),
        .restart_n (restart_n),
        .io        (ifc)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Hold enter_btn for 12 edges then release for 10; report pulse counts
    // and the loop index of the first pulse (-1 if none).
    task automatic press(input logic [3:0] st, input logic [3:0] v,
                         output int n_ent, output int n_err, output int idx);
        n_ent = 0; n_err = 0; idx = -1;
        ifc.state = st;
        ifc.sw    = v;
        ifc.enter_btn = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 12) ifc.enter_btn = 1'b0;
            tick();
            if (ifc.enter)     n_ent++;
            if (ifc.input_err) n_err++;
            if ((ifc.enter || ifc.input_err) && idx < 0) idx = i;
        end
    endtask

    typedef struct {
        logic [3:0] st;
        logic [3:0] v;
        int         ent;
        int         err;
        logic [3:0] sw_after;
    } vec_t;

    vec_t vt[10];

    initial begin
        int ne, nr, ix;

        // state, sw, enter pulses, err pulses, sw_val afterwards
        vt[0] = '{4'b0011, 4'd2,  1, 0, 4'd2};
        vt[1] = '{4'b0011, 4'd3,  0, 1, 4'd2};
        vt[2] = '{4'b0101, 4'd8,  1, 0, 4'd8};
        vt[3] = '{4'b0101, 4'd9,  0, 1, 4'd8};
        vt[4] = '{4'b0110, 4'd9,  1, 0, 4'd9};
        vt[5] = '{4'b0110, 4'd10, 0, 1, 4'd9};
        vt[6] = '{4'b0000, 4'd15, 1, 0, 4'd15};
        vt[7] = '{4'b0010, 4'd12, 1, 0, 4'd12};
        vt[8] = '{4'b0111, 4'd1,  0, 0, 4'd12};
        vt[9] = '{4'b0110, 4'd1,  1, 0, 4'd1};

        // ---- reset ----
        restart_n = 1'b0;
        ifc.enter_btn = 1'b0; ifc.restart_btn = 1'b0;
        ifc.sw = 4'd7; ifc.state = 4'b0000;
        tick(); tick();
        chk("rst_enter",   ifc.enter,     0);
        chk("rst_restart", ifc.restart,   0);
        chk("rst_err",     ifc.input_err, 0);
        chk("rst_swval",   ifc.sw_val,    0);
        restart_n = 1'b1;
        tick(); tick();

        // ---- valid press, exact latency, no repeat while held ----
        ifc.state = 4'b0100; ifc.sw = 4'd5; ifc.enter_btn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("lat_enter_%0d", i), ifc.enter, (i == 6));
            chk($sformatf("lat_err_%0d", i), ifc.input_err, 0);
        end
        chk("lat_swval", ifc.sw_val, 5);
        ne = 0;
        for (int i = 0; i < 10; i++) begin tick(); ne += ifc.enter; end
        chk("held_no_repeat", ne, 0);
        ifc.enter_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // ---- out-of-range press ----
        ifc.state = 4'b0110; ifc.sw = 4'd0; ifc.enter_btn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("err_pulse_%0d", i), ifc.input_err, (i == 6));
            chk($sformatf("err_enter_%0d", i), ifc.enter, 0);
        end
        chk("err_swval_kept", ifc.sw_val, 5);
        ifc.enter_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // ---- bounce shorter than debounce window ----
        ifc.state = 4'b0100; ifc.sw = 4'd3;
        ne = 0; nr = 0;
        for (int i = 0; i < 30; i++) begin
            ifc.enter_btn = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
            tick();
            ne += ifc.enter; nr += ifc.input_err;
        end
        chk("bounce_enter", ne, 0);
        chk("bounce_err",   nr, 0);
        chk("bounce_swval", ifc.sw_val, 5);

        // ---- ignored state, then valid press ----
        press(4'b1001, 4'd3, ne, nr, ix);
        chk("ign_enter", ne, 0);
        chk("ign_err",   nr, 0);
        press(4'b0011, 4'd2, ne, nr, ix);
        chk("after_ign_enter", ne, 1);
        chk("after_ign_idx",   ix, 6);
        chk("after_ign_swval", ifc.sw_val, 2);

        // ---- range boundaries ----
        foreach (vt[k]) begin
            press(vt[k].st, vt[k].v, ne, nr, ix);
            chk($sformatf("tbl%0d_enter", k), ne, vt[k].ent);
            chk($sformatf("tbl%0d_err", k), nr, vt[k].err);
            chk($sformatf("tbl%0d_swval", k), ifc.sw_val, vt[k].sw_after);
        end

        // ---- restart and enter raised together ----
        ifc.state = 4'b0100; ifc.sw = 4'd7;
        ifc.enter_btn = 1'b1; ifc.restart_btn = 1'b1;
        ne = 0; nr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 9) chk($sformatf("rs_restart_%0d", i), ifc.restart, (i >= 5));
            ne += ifc.enter; nr += ifc.input_err;
        end
        chk("rs_no_enter", ne, 0);
        chk("rs_no_err",   nr, 0);
        ifc.enter_btn = 1'b0; ifc.restart_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rs_released", ifc.restart, 0);
        press(4'b0100, 4'd7, ne, nr, ix);
        chk("rs_next_enter", ne, 1);
        chk("rs_next_idx",   ix, 6);
        chk("rs_next_swval", ifc.sw_val, 7);

        // ---- reset in the middle of debounce, button kept held ----
        ifc.state = 4'b0100; ifc.sw = 4'd1; ifc.enter_btn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        restart_n = 1'b0;
        tick();
        chk("mid_rst_enter",   ifc.enter,     0);
        chk("mid_rst_restart", ifc.restart,   0);
        chk("mid_rst_err",     ifc.input_err, 0);
        chk("mid_rst_swval",   ifc.sw_val,    0);
        restart_n = 1'b1;
        ne = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < 9) chk($sformatf("post_rst_enter_%0d", i), ifc.enter, (i == 6));
            ne += ifc.enter;
        end
        chk("post_rst_single", ne, 1);
        chk("post_rst_swval", ifc.sw_val, 1);
        ifc.enter_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
